// File: rtl/pipelined_adder_n_if.sv
// Operand/result handshake bundle for pipelined_adder_n.
// The master drives operands, flush and result ready; the slave returns ready and the result.
interface pipelined_adder_n_if #(
  parameter int N = 64
);
  logic         flush_i;
  logic         valid_i;
  logic         ready_o;
  logic         sub_i;
  logic         c_i;
  logic [N-1:0] a_i;
  logic [N-1:0] b_i;
  logic         valid_o;
  logic         ready_i;
  logic [N-1:0] s_o;
  logic         c_o;
  logic         v_o;
  logic         z_o;

  modport master (
    output flush_i, valid_i, sub_i, c_i, a_i, b_i, ready_i,
    input  ready_o, valid_o, s_o, c_o, v_o, z_o
  );

  modport slave (
    input  flush_i, valid_i, sub_i, c_i, a_i, b_i, ready_i,
    output ready_o, valid_o, s_o, c_o, v_o, z_o
  );
endinterface

// File: rtl/pipelined_adder_n.sv
// Segmented N-bit add/sub resolving one CHUNK per stage, carry registered between stages.
// Latency STAGES cycles, 1 beat/cycle; a stalled output freezes every stage and drops ready_o.
module pipelined_adder_n #(
  parameter int N      = 64,
  parameter int STAGES = 4
) (
  input logic                clk_i,
  input logic                rst_ni,
  pipelined_adder_n_if.slave bus
);
  localparam int CW = N / STAGES;
  localparam int L  = STAGES - 1;
  localparam logic [N-1:0] CMASK = {N{1'b1}} >> (N - CW);

  if (N % STAGES != 0) begin : g_bad_split
    $error("pipelined_adder_n: N must be a multiple of STAGES");
  end

  logic         stall;
  logic [N-1:0] a_q [STAGES];
  logic [N-1:0] b_q [STAGES];
  logic [N-1:0] s_q [STAGES];
  logic         cy_q  [STAGES];
  logic         vld_q [STAGES];

  // Per-stage inputs: operands as they enter stage k, plus the partial sum of lower chunks.
  logic [N-1:0] a_d  [STAGES];
  logic [N-1:0] b_d  [STAGES];
  logic [N-1:0] sp_d [STAGES];
  logic [N-1:0] s_d  [STAGES];
  logic         cin_d [STAGES];
  logic         vld_d [STAGES];
  logic [CW:0]  ch_sum [STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign a_d[k]   = bus.a_i;
      assign b_d[k]   = bus.sub_i ? ~bus.b_i : bus.b_i;
      assign sp_d[k]  = '0;
      assign cin_d[k] = bus.sub_i | bus.c_i;
      assign vld_d[k] = bus.valid_i;
    end else begin : g_body
      assign a_d[k]   = a_q[k-1];
      assign b_d[k]   = b_q[k-1];
      assign sp_d[k]  = s_q[k-1];
      assign cin_d[k] = cy_q[k-1];
      assign vld_d[k] = vld_q[k-1];
    end

    assign ch_sum[k] = {1'b0, a_d[k][k*CW +: CW]} + {1'b0, b_d[k][k*CW +: CW]}
                     + {{CW{1'b0}}, cin_d[k]};
    assign s_d[k] = (sp_d[k] & ~(CMASK << (k*CW))) | (N'(ch_sum[k][CW-1:0]) << (k*CW));
  end

  assign stall       = vld_q[L] & ~bus.ready_i;
  assign bus.ready_o = ~stall;

  // Flush beats stall: valids clear even while the output is held, data simply stays put.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        cy_q[k]  <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (bus.flush_i) begin
          vld_q[k] <= 1'b0;
        end else if (!stall) begin
          vld_q[k] <= vld_d[k];
        end
        if (!stall) begin
          cy_q[k] <= ch_sum[k][CW];
          a_q[k]  <= a_d[k];
          b_q[k]  <= b_d[k];
          s_q[k]  <= s_d[k];
        end
      end
    end
  end

  assign bus.valid_o = vld_q[L];
  assign bus.s_o     = vld_q[L] ? s_q[L] : '0;
  assign bus.c_o     = vld_q[L] & cy_q[L];
  assign bus.v_o     = vld_q[L] & (a_q[L][N-1] == b_q[L][N-1]) & (s_q[L][N-1] != a_q[L][N-1]);
  assign bus.z_o     = vld_q[L] & (s_q[L] == '0);
endmodule

// File: tb/tb_pipelined_adder_n.sv
// Randomised and directed bench for pipelined_adder_n against a whole-word arithmetic model.
// Main DUT uses 4 stages; 1- and 8-stage copies confirm latency scaling.
module tb_pipelined_adder_n;
  localparam int N = 64;

  typedef struct packed {
    logic         c;
    logic         v;
    logic         z;
    logic [N-1:0] s;
  } res_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_adder_n_if #(.N(N)) bus4 ();
  pipelined_adder_n_if #(.N(N)) bus1 ();
  pipelined_adder_n_if #(.N(N)) bus8 ();

  pipelined_adder_n #(.N(N), .STAGES(4)) u_dut4 (.clk_i(clk), .rst_ni(rst_n), .bus(bus4.slave));
  pipelined_adder_n #(.N(N), .STAGES(1)) u_dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(bus1.slave));
  pipelined_adder_n #(.N(N), .STAGES(8)) u_dut8 (.clk_i(clk), .rst_ni(rst_n), .bus(bus8.slave));

  int   n_cmp = 0;
  int   n_bad = 0;
  res_t exp_q[$];
  res_t got_q[$];
  int   run_len = 0;
  int   max_run = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic res_t mk(input logic c, input logic v, input logic z, input logic [N-1:0] s);
    res_t r;
    r.c = c; r.v = v; r.z = z; r.s = s;
    return r;
  endfunction

  // Whole-word reference: unsigned result/carry and true signed range check.
  function automatic res_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic sub, input logic cin);
    logic [N:0]   w;
    logic [N+1:0] t;
    res_t         r;
    if (sub) begin
      w   = {1'b0, a} - {1'b0, b};
      r.c = (a >= b);
      t   = {{2{a[N-1]}}, a} - {{2{b[N-1]}}, b};
    end else begin
      w   = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
      r.c = w[N];
      t   = {{2{a[N-1]}}, a} + {{2{b[N-1]}}, b} + {{(N+1){1'b0}}, cin};
    end
    r.s = w[N-1:0];
    r.v = !((t[N+1] == t[N]) && (t[N] == t[N-1]));
    r.z = (r.s == '0);
    return r;
  endfunction

  function automatic res_t got_at(input int i);
    return (i < got_q.size()) ? got_q[i] : '1;
  endfunction

  function automatic logic [N-1:0] rnd_op();
    case ($urandom % 5)
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(N-1){1'b0}}};
      3:       return {1'b0, {(N-1){1'b1}}};
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  // Scoreboard on the 4-stage DUT, sampled on the falling edge.
  res_t prev_out;
  logic prev_stalled = 1'b0;
  always @(negedge clk) begin : mon
    res_t cur;
    cur = {bus4.c_o, bus4.v_o, bus4.z_o, bus4.s_o};
    if (!rst_n) begin
      exp_q.delete();
      prev_stalled = 1'b0;
      run_len      = 0;
    end else begin
      if (bus4.valid_o) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid_o", 1'b1, 1'b0);
        end else begin
          chk("result", cur, exp_q[0]);
        end
        if (prev_stalled) chk("stall_hold", cur, prev_out);
        if (bus4.ready_i) begin
          got_q.push_back(cur);
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        prev_out     = cur;
        prev_stalled = !bus4.ready_i && !bus4.flush_i;
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        chk("idle_outputs_zero", cur, '0);
        prev_stalled = 1'b0;
        run_len      = 0;
      end
      chk("ready_o", bus4.ready_o, !(bus4.valid_o && !bus4.ready_i));
      if (bus4.flush_i) exp_q.delete();
      else if (bus4.valid_i && bus4.ready_o)
        exp_q.push_back(model(bus4.a_i, bus4.b_i, bus4.sub_i, bus4.c_i));
    end
  end

  task automatic idle_all();
    bus4.valid_i = 0; bus4.flush_i = 0; bus4.ready_i = 1; bus4.sub_i = 0; bus4.c_i = 0;
    bus4.a_i = '0; bus4.b_i = '0;
    bus1.valid_i = 0; bus1.flush_i = 0; bus1.ready_i = 1; bus1.sub_i = 0; bus1.c_i = 0;
    bus1.a_i = '0; bus1.b_i = '0;
    bus8.valid_i = 0; bus8.flush_i = 0; bus8.ready_i = 1; bus8.sub_i = 0; bus8.c_i = 0;
    bus8.a_i = '0; bus8.b_i = '0;
  endtask

  // Offers one beat on bus4 until accepted; leaves valid_i high, returns at posedge+1.
  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub, input logic cin);
    logic acc;
    bus4.a_i = a; bus4.b_i = b; bus4.sub_i = sub; bus4.c_i = cin; bus4.valid_i = 1;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = bus4.ready_o;
      @(posedge clk); #1;
    end
    chk("send_accept", acc, 1'b1);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat4, lat1, lat8;
    res_t cap1, cap8;
    idle_all();

    // Reset state
    #1;
    chk("rst_valid_o", bus4.valid_o, 1'b0);
    chk("rst_outputs", {bus4.c_o, bus4.v_o, bus4.z_o, bus4.s_o}, '0);
    chk("rst_ready_o", bus4.ready_o, 1'b1);
    chk("rst_valid_o_s8", bus8.valid_o, 1'b0);
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Full carry ripple on all three depths, with latency measurement
    got_q.delete();
    bus4.a_i = '1; bus4.b_i = 64'd1; bus4.valid_i = 1;
    bus1.a_i = '1; bus1.b_i = 64'd1; bus1.valid_i = 1;
    bus8.a_i = '1; bus8.b_i = 64'd1; bus8.valid_i = 1;
    @(negedge clk);
    chk("t1_accept", {bus1.ready_o, bus4.ready_o, bus8.ready_o}, 3'b111);
    @(posedge clk); #1;
    bus4.valid_i = 0; bus1.valid_i = 0; bus8.valid_i = 0;
    lat4 = -1; lat1 = -1; lat8 = -1; cap1 = '1; cap8 = '1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (bus4.valid_o && lat4 < 0) lat4 = cyc;
      if (bus1.valid_o && lat1 < 0) begin
        lat1 = cyc; cap1 = {bus1.c_o, bus1.v_o, bus1.z_o, bus1.s_o};
      end
      if (bus8.valid_o && lat8 < 0) begin
        lat8 = cyc; cap8 = {bus8.c_o, bus8.v_o, bus8.z_o, bus8.s_o};
      end
    end
    @(posedge clk); #1;
    chk("t1_latency_s4", lat4, 4);
    chk("t1_latency_s1", lat1, 1);
    chk("t1_latency_s8", lat8, 8);
    chk("t1_count_s4", got_q.size(), 1);
    chk("t1_result_s4", got_at(0), mk(1'b1, 1'b0, 1'b1, 64'h0));
    chk("t1_result_s1", cap1, mk(1'b1, 1'b0, 1'b1, 64'h0));
    chk("t1_result_s8", cap8, mk(1'b1, 1'b0, 1'b1, 64'h0));

    // Subtraction edge cases and add with carry-in
    got_q.delete();
    send(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0);
    send(64'd3, 64'd5, 1'b1, 1'b1);
    send(64'd10, 64'd20, 1'b0, 1'b1);
    bus4.valid_i = 0;
    wait_cycles(8);
    chk("t2_count", got_q.size(), 3);
    chk("t2_sub_ovf", got_at(0), mk(1'b1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF));
    chk("t2_sub_borrow", got_at(1), mk(1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE));
    chk("t2_add_cin", got_at(2), mk(1'b0, 1'b0, 1'b0, 64'd31));

    // Eight back-to-back beats
    got_q.delete();
    max_run = 0;
    for (int i = 0; i < 8; i++) send(rnd_op(), rnd_op(), 1'($urandom % 2), 1'($urandom % 2));
    bus4.valid_i = 0;
    wait_cycles(8);
    chk("t3_count", got_q.size(), 8);
    chk("t3_consecutive", max_run, 8);

    // Stall a full pipe for three cycles
    got_q.delete();
    bus4.ready_i = 0;
    for (int i = 0; i < 4; i++) send(rnd_op(), rnd_op(), 1'($urandom % 2), 1'($urandom % 2));
    bus4.a_i = {$urandom(), $urandom()}; bus4.b_i = {$urandom(), $urandom()};
    bus4.valid_i = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_ready_low", bus4.ready_o, 1'b0);
      chk("t4_valid_held", bus4.valid_o, 1'b1);
      @(posedge clk); #1;
    end
    bus4.ready_i = 1;
    send(bus4.a_i, bus4.b_i, bus4.sub_i, bus4.c_i);
    bus4.valid_i = 0;
    wait_cycles(10);
    chk("t4_count", got_q.size(), 5);

    // Flush with three in flight plus one offered
    got_q.delete();
    for (int i = 0; i < 3; i++) send(rnd_op(), rnd_op(), 1'($urandom % 2), 1'($urandom % 2));
    bus4.a_i = 64'd7; bus4.b_i = 64'd9; bus4.valid_i = 1; bus4.flush_i = 1;
    @(posedge clk); #1;
    bus4.flush_i = 0; bus4.valid_i = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_flushed_valid_o", bus4.valid_o, 1'b0);
      @(posedge clk); #1;
    end
    send(64'h1234, 64'h1111, 1'b0, 1'b0);
    bus4.valid_i = 0;
    wait_cycles(8);
    chk("t5_count", got_q.size(), 1);
    chk("t5_post_flush", got_at(0), mk(1'b0, 1'b0, 1'b0, 64'h2345));

    // Asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) send(rnd_op() | 64'h10, rnd_op(), 1'b0, 1'b0);
    bus4.valid_i = 0;
    #2;
    chk("t6_valid_before_rst", bus4.valid_o, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid_o", bus4.valid_o, 1'b0);
    chk("t6_rst_outputs", {bus4.c_o, bus4.v_o, bus4.z_o, bus4.s_o}, '0);
    chk("t6_rst_ready_o", bus4.ready_o, 1'b1);
    @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Random traffic with backpressure, bubbles and occasional flushes
    for (int i = 0; i < 600; i++) begin
      bus4.valid_i = ($urandom % 4) != 0;
      bus4.ready_i = ($urandom % 4) != 0;
      bus4.flush_i = ($urandom % 40) == 0;
      bus4.sub_i   = 1'($urandom % 2);
      bus4.c_i     = 1'($urandom % 2);
      bus4.a_i     = rnd_op();
      bus4.b_i     = rnd_op();
      @(posedge clk); #1;
    end
    bus4.valid_i = 0; bus4.flush_i = 0; bus4.ready_i = 1;
    wait_cycles(12);
    chk("drain_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
